// File: rtl/pseudo_linear_pkg.sv
// Shared types and helpers for the sequential pseudo-linear binary learner.
package pseudo_linear_pkg;

  typedef enum logic [2:0] {IDLE, COUNT, DECIDE, UPDATE, RESULT} state_t;

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // Forward decision: fires when the shifted parameter count falls below the overlap count.
  function automatic logic fwd(input int unsigned nb, input int unsigned np,
                               input int unsigned thr);
    return (np >> thr) < nb;
  endfunction

endpackage

// File: rtl/pl_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice.
module pl_chunk_popcount #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0]           bits,
  output logic [$clog2(CHUNK+1)-1:0] count
);

  localparam int OW = $clog2(CHUNK + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) count = count + OW'(bits[i]);
  end

endmodule

// File: rtl/pseudo_linear_learner_seq.sv
// Multi-cycle pseudo-linear learner: counts CHUNK bits per clock, then optionally
// applies the reverse-derivative flip to the parameter vector CHUNK bits per clock.
module pseudo_linear_learner_seq
  import pseudo_linear_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int CHUNK = 16,
  parameter int TW    = 4,
  localparam int CW   = cw_of(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [TW-1:0]   threshold,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N_IN-1:0] s_x,
  input  logic            s_label,
  input  logic            s_train,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_pred,
  output logic            m_err,
  output logic [CW-1:0]   m_flips,
  output logic [N_IN-1:0] p_out,
  output logic            busy
);

  localparam int NCH = N_IN / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PCW = $clog2(CHUNK + 1);

  state_t            state, state_nxt;
  logic [N_IN-1:0]   p, x_q;
  logic              label_q, train_q;
  logic [TW-1:0]     thr_q;
  logic [CW-1:0]     nb, np, flips;
  logic [IW-1:0]     idx;
  logic              pred, err;
  logic [CHUNK-1:0]  p_ch, x_ch, d;
  logic [PCW-1:0]    pc_px, pc_p, pc_d;
  logic              last, dec_pred, dec_err;
  int                base;

  assign base     = int'(idx) * CHUNK;
  assign p_ch     = p[base +: CHUNK];
  assign x_ch     = x_q[base +: CHUNK];
  assign last     = (idx == IW'(NCH - 1));
  assign dec_pred = fwd(32'(nb), 32'(np), 32'(thr_q));
  assign dec_err  = dec_pred ^ label_q;

  pl_chunk_popcount #(.CHUNK(CHUNK)) u_pc_px (.bits(p_ch & x_ch), .count(pc_px));
  pl_chunk_popcount #(.CHUNK(CHUNK)) u_pc_p  (.bits(p_ch),        .count(pc_p));
  pl_chunk_popcount #(.CHUNK(CHUNK)) u_pc_d  (.bits(d),           .count(pc_d));

  // Flip mask: a bit flips when toggling it alone would change the decision.
  always_comb begin
    int unsigned nbv, npv, nbp, npp;
    d   = '0;
    nbv = 32'(nb);
    npv = 32'(np);
    nbp = 0;
    npp = 0;
    for (int m = 0; m < CHUNK; m++) begin
      nbp  = x_ch[m] ? (p_ch[m] ? nbv - 1 : nbv + 1) : nbv;
      npp  = p_ch[m] ? npv - 1 : npv + 1;
      d[m] = pred ^ fwd(nbp, npp, 32'(thr_q));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = COUNT;
      COUNT:   if (last) state_nxt = DECIDE;
      DECIDE:  state_nxt = (train_q && dec_err) ? UPDATE : RESULT;
      UPDATE:  if (last) state_nxt = RESULT;
      RESULT:  if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Sample capture at accept; held untouched until the next accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && s_valid && !clear) begin
      x_q     <= s_x;
      label_q <= s_label;
      train_q <= s_train;
      thr_q   <= threshold;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0; nb <= '0; np <= '0; idx <= '0;
      pred <= 1'b0; err <= 1'b0; flips <= '0;
    end else if (clear) begin
      p <= '0; nb <= '0; np <= '0; idx <= '0;
      pred <= 1'b0; err <= 1'b0; flips <= '0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          nb <= '0; np <= '0; idx <= '0; flips <= '0;
        end
        COUNT: begin
          nb  <= nb + CW'(pc_px);
          np  <= np + CW'(pc_p);
          idx <= last ? '0 : idx + IW'(1);
        end
        DECIDE: begin
          pred <= dec_pred;
          err  <= dec_err;
        end
        UPDATE: begin
          p[base +: CHUNK] <= p_ch ^ d;
          flips            <= flips + CW'(pc_d);
          idx              <= last ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign m_valid = (state == RESULT);
  assign m_pred  = pred;
  assign m_err   = err;
  assign m_flips = flips;
  assign p_out   = p;

endmodule
